// File: rtl/line_mem_arbiter_if.sv
// rtl/line_mem_arbiter_if.sv - I/D line request ports plus 64-bit burst memory port
// slave: the arbiter's view; master: the caches and memory around it.
interface line_mem_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
);
    logic                  i_read;
    logic [31:0]           i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;
    logic                  d_read;
    logic                  d_write;
    logic [31:0]           d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_address;
    logic [BEAT_WIDTH-1:0] mem_wdata;
    logic [BEAT_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - shares one 4-beat burst memory port between I-cache and D-cache lines
// Optional LINE_MEM_ARBITER_RR_EN: round-robin between I and D when both are pending.
module line_mem_arbiter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BEAT_WIDTH  = 64,
    parameter int OFFSET_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    line_mem_arbiter_if.slave    bus
);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP} state_t;

    state_t                r_state;
    logic [1:0]            r_cnt;
    logic [LINE_WIDTH-1:0] r_wline;
    logic [LINE_WIDTH-1:0] r_i_rdata;
    logic [LINE_WIDTH-1:0] r_d_rdata;
    logic                  r_i_resp;
    logic                  r_d_resp;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [31:0]           r_mem_address;
    logic                  w_grant_d;

`ifdef LINE_MEM_ARBITER_RR_EN
    logic                  r_last_d;
    // D yields a tie only when it was the side served last.
    assign w_grant_d = bus.d_write | (bus.d_read & ~(bus.i_read & r_last_d));
`else
    assign w_grant_d = bus.d_write | bus.d_read;
`endif

    assign bus.i_rdata     = r_i_rdata;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.i_resp      = r_i_resp;
    assign bus.d_resp      = r_d_resp;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_mem_address;
    // The writeback line shifts down one beat per mem_resp, so the low slice is always the current beat.
    assign bus.mem_wdata   = r_wline[BEAT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_wline       <= '0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_i_resp      <= 1'b0;
            r_d_resp      <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
`ifdef LINE_MEM_ARBITER_RR_EN
            r_last_d      <= 1'b0;
`endif
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_d) begin
                        r_mem_address <= bus.d_address & ADDR_MASK;
                        if (bus.d_write) begin
                            r_state     <= D_WR;
                            r_mem_write <= 1'b1;
                            r_wline     <= bus.d_wdata;
                        end else begin
                            r_state    <= D_RD;
                            r_mem_read <= 1'b1;
                        end
                    end else if (bus.i_read) begin
                        r_state       <= I_RD;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= bus.i_address & ADDR_MASK;
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (bus.mem_resp) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_state == I_RD)
                            r_i_rdata[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mem_rdata;
                        if (r_state == D_RD)
                            r_d_rdata[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mem_rdata;
                        if (r_state == D_WR)
                            r_wline <= r_wline >> BEAT_WIDTH;
                        if (r_cnt == 2'd3) begin
                            r_state     <= RESP;
                            r_mem_read  <= 1'b0;
                            r_mem_write <= 1'b0;
                            r_i_resp    <= (r_state == I_RD);
                            r_d_resp    <= (r_state != I_RD);
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
`ifdef LINE_MEM_ARBITER_RR_EN
                    r_last_d <= r_d_resp;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb/tb_line_mem_arbiter.sv - directed cycle-exact bench for line_mem_arbiter with a line/beat scoreboard
module tb_line_mem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   n;
    logic last_d;
    logic first_d;
    logic [255:0] rq[$];
    logic [63:0]  wq[$];
    logic [255:0] line1, line_a, line_b, line4, line_r, line6, wline;
    logic [31:0]  addr_a, addr_b;

    line_mem_arbiter_if bus ();

    line_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_wbeats(input logic [255:0] l);
        for (int k = 0; k < 4; k++) wq.push_back(l[64*k +: 64]);
    endtask

    // Memory side of one burst; entered in the first cycle mem_read/mem_write is visible.
    task automatic serve(input logic wr, input int first_gap, input int gap,
                         input logic [255:0] line, input logic [31:0] exp_addr);
        int g;
        for (int k = 0; k < 4; k++) begin
            g = (k == 0) ? first_gap : gap;
            for (int w = 0; w < g; w++) begin
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                chk("hold_read", bus.mem_read, !wr);
                chk("hold_write", bus.mem_write, wr);
                chk("hold_addr", bus.mem_address, exp_addr);
                tick;
            end
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = line[64*k +: 64];
            chk("beat_read", bus.mem_read, !wr);
            chk("beat_write", bus.mem_write, wr);
            if (wr) chk("beat_wdata", bus.mem_wdata, wq.pop_front());
            tick;
        end
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; last_d = 1'b0;
        rst = 1'b0;
        bus.i_read = 0; bus.i_address = '0; bus.d_read = 0; bus.d_write = 0;
        bus.d_address = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_resp = 0;
        tick; tick;
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_address, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_resp", {bus.i_resp, bus.d_resp}, 0);
        rst = 1'b1;
        tick;

        // Single I read, zero-wait memory.
        line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        bus.i_address = 32'h0000_1234;
        bus.i_read = 1'b1;
        rq.push_back(line1);
        n = cyc;
        tick;
        chk("i_mem_read", bus.mem_read, 1);
        chk("i_mem_addr", bus.mem_address, 32'h0000_1220);
        serve(1'b0, 1, 0, line1, 32'h0000_1220);
        chk("i_latency", cyc - n, 6);
        chk("i_resp", bus.i_resp, 1);
        chk("i_no_d_resp", bus.d_resp, 0);
        chk("i_rdata", bus.i_rdata, rq.pop_front());
        chk("i_end_read", bus.mem_read, 0);
        bus.i_read = 1'b0;
        tick;
        chk("i_resp_pulse", bus.i_resp, 0);
        chk("i_rdata_hold", bus.i_rdata, line1);
        last_d = 1'b0;

        // D writeback.
        wline = {64'hDDDD_DDDD_DDDD_0003, 64'hDDDD_DDDD_DDDD_0002,
                 64'hDDDD_DDDD_DDDD_0001, 64'hDDDD_DDDD_DDDD_0000};
        bus.d_address = 32'h8000_0040;
        bus.d_wdata = wline;
        bus.d_write = 1'b1;
        push_wbeats(wline);
        tick;
        chk("w_mem_addr", bus.mem_address, 32'h8000_0040);
        serve(1'b1, 1, 0, '0, 32'h8000_0040);
        chk("w_d_resp", bus.d_resp, 1);
        chk("w_no_i_resp", bus.i_resp, 0);
        chk("w_end_write", bus.mem_write, 0);
        bus.d_write = 1'b0;
        tick;
        chk("w_resp_pulse", bus.d_resp, 0);
        chk("w_d_rdata_untouched", bus.d_rdata, 0);
        last_d = 1'b1;

        // I and D reads raised together.
`ifdef LINE_MEM_ARBITER_RR_EN
        first_d = !last_d;
`else
        first_d = 1'b1;
`endif
        line_a = rnd_line();
        line_b = rnd_line();
        bus.d_address = 32'h0000_2000;
        bus.i_address = 32'h0000_3010;
        addr_a = first_d ? 32'h0000_2000 : 32'h0000_3000;
        addr_b = first_d ? 32'h0000_3000 : 32'h0000_2000;
        bus.d_read = 1'b1;
        bus.i_read = 1'b1;
        rq.push_back(line_a);
        rq.push_back(line_b);
        tick;
        chk("arb_first_addr", bus.mem_address, addr_a);
        serve(1'b0, 1, 0, line_a, addr_a);
        chk("arb_first_d_resp", bus.d_resp, first_d);
        chk("arb_first_i_resp", bus.i_resp, !first_d);
        chk("arb_first_rdata", first_d ? bus.d_rdata : bus.i_rdata, rq.pop_front());
        if (first_d) bus.d_read = 1'b0; else bus.i_read = 1'b0;
        tick;
        chk("arb_idle_gap", bus.mem_read, 0);
        tick;
        chk("arb_second_read", bus.mem_read, 1);
        chk("arb_second_addr", bus.mem_address, addr_b);
        serve(1'b0, 1, 0, line_b, addr_b);
        chk("arb_second_d_resp", bus.d_resp, !first_d);
        chk("arb_second_i_resp", bus.i_resp, first_d);
        chk("arb_second_rdata", first_d ? bus.i_rdata : bus.d_rdata, rq.pop_front());
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
        tick;
        last_d = !first_d;

        // Wait-state memory, requester drops right after grant.
        line4 = rnd_line();
        bus.i_address = 32'h0000_4444;
        bus.i_read = 1'b1;
        rq.push_back(line4);
        n = cyc;
        tick;
        bus.i_read = 1'b0;
        serve(1'b0, 2, 2, line4, 32'h0000_4440);
        chk("ws_latency", cyc - n, 13);
        chk("ws_i_resp", bus.i_resp, 1);
        chk("ws_i_rdata", bus.i_rdata, rq.pop_front());
        tick;
        chk("ws_idle", bus.mem_read, 0);
        last_d = 1'b0;

        // Reset after the 2nd beat of a D read.
        line_r = rnd_line();
        bus.d_address = 32'h0000_5000;
        bus.d_read = 1'b1;
        tick;
        bus.mem_resp = 1'b0;
        tick;
        bus.mem_resp = 1'b1; bus.mem_rdata = line_r[63:0];
        tick;
        bus.mem_rdata = line_r[127:64];
        tick;
        rst = 1'b0;
        bus.mem_resp = 1'b0;
        bus.d_read = 1'b0;
        tick;
        chk("mid_rst_read", bus.mem_read, 0);
        chk("mid_rst_write", bus.mem_write, 0);
        chk("mid_rst_addr", bus.mem_address, 0);
        chk("mid_rst_wdata", bus.mem_wdata, 0);
        chk("mid_rst_i_rdata", bus.i_rdata, 0);
        chk("mid_rst_d_rdata", bus.d_rdata, 0);
        chk("mid_rst_resp", {bus.i_resp, bus.d_resp}, 0);
        rst = 1'b1;
        last_d = 1'b0;
        tick;
        bus.mem_resp = 1'b1; bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick;
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        chk("stray_resp_read", bus.mem_read, 0);
        chk("stray_resp_rdata", bus.i_rdata, 0);
        line6 = rnd_line();
        bus.i_address = 32'h0000_6000;
        bus.i_read = 1'b1;
        rq.push_back(line6);
        n = cyc;
        tick;
        serve(1'b0, 1, 0, line6, 32'h0000_6000);
        chk("post_rst_latency", cyc - n, 6);
        chk("post_rst_i_resp", bus.i_resp, 1);
        chk("post_rst_i_rdata", bus.i_rdata, rq.pop_front());
        bus.i_read = 1'b0;
        tick;

        // d_read and d_write together: write wins, read dropped in RESP.
        wline = rnd_line();
        bus.d_address = 32'h0000_7000;
        bus.d_wdata = wline;
        bus.d_read = 1'b1;
        bus.d_write = 1'b1;
        push_wbeats(wline);
        tick;
        chk("rw_mem_write", bus.mem_write, 1);
        chk("rw_no_read", bus.mem_read, 0);
        serve(1'b1, 1, 0, '0, 32'h0000_7000);
        chk("rw_d_resp", bus.d_resp, 1);
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        tick;
        chk("rw_resp_once", bus.d_resp, 0);
        tick;
        chk("rw_no_follow_read", {bus.mem_read, bus.mem_write}, 0);
        chk("rw_d_rdata", bus.d_rdata, 0);
        chk("sb_drained", rq.size() + wq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares the single 64-bit burst memory port between I-cache and D-cache line traffic inside the cache hierarchy.
- Each requester issues 256-bit line reads; the D-cache also issues 256-bit line writebacks.
- Each line transfer becomes a 4-beat burst on the memory port.
- Returns the assembled line with a one-cycle response pulse to the granted requester.

Parameters:
- LINE_WIDTH, 256, cache line width in bits; must equal BEAT_WIDTH*4.
- BEAT_WIDTH, 64, memory beat width in bits.
- OFFSET_BITS, 5, line-offset bits forced to zero on mem_address.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; rst==0 at posedge resets the block.
- i_read  in  1  I-cache line read request; level, held until i_resp.
- i_address  in  32  I-cache line address.
- i_rdata  out  LINE_WIDTH  assembled line for the I-cache.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line read request; level.
- d_write  in  1  D-cache writeback request; level.
- d_address  in  32  D-cache line address.
- d_wdata  in  LINE_WIDTH  writeback line.
- d_rdata  out  LINE_WIDTH  assembled line for the D-cache.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- mem_read  out  1  burst read; held for the whole burst.
- mem_write  out  1  burst write; held for the whole burst.
- mem_address  out  32  line-aligned burst address.
- mem_wdata  out  BEAT_WIDTH  current write beat.
- mem_rdata  in  BEAT_WIDTH  current read beat.
- mem_resp  in  1  beat accepted/valid; one pulse per beat.

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE and the beat counter clears.
  - All outputs go to 0, including i_rdata, d_rdata and mem_address.
  - A reset mid-burst abandons the burst immediately; mem_read/mem_write drop the next cycle.
- States: IDLE, I_RD, D_RD, D_WR, RESP.
- Arbitration happens only in IDLE:
  - With no Optional Feature, the D-cache has fixed priority.
  - d_write beats d_read; if both are high, write is performed and d_read is ignored.
  - The I-cache is granted only when d_read==0 and d_write==0.
- On grant:
  - Latch the address with low OFFSET_BITS forced to 0, plus the requester ID and, for writes, d_wdata.
  - Enter the burst state. mem_read or mem_write is registered and asserted the cycle after grant.
- During a burst:
  - A 2-bit beat counter advances on each mem_resp.
  - Beat k maps to line bits [64k+63:64k], beat 0 least significant.
  - Reads: mem_rdata is captured into the granted requester's rdata slice k on mem_resp.
  - Writes: mem_wdata equals the latched line slice k for the current counter value.
- On the 4th mem_resp:
  - Deassert mem_read/mem_write the next cycle and enter RESP.
  - Pulse i_resp or d_resp (never both) for exactly one cycle.
  - rdata holds the full line that cycle and afterwards until the next read burst to that requester.
- RESP always goes to IDLE.
  - The requester must drop its request in the RESP cycle.
  - A request still high in IDLE is treated as new.
- Minimum line latency with zero-wait memory:
  - grant cycle + 4 beats + RESP.
  - req high at cycle N → resp at N+6 when mem_resp is high every cycle from N+2.
- Requester deasserting mid-burst: ignored; the burst completes and resp still pulses.
- mem_resp outside a burst: ignored.
- A new request arriving during a burst waits; it is arbitrated at the next IDLE.
- mem_read and mem_write are never high together.

Optional Feature:
- Macro: LINE_MEM_ARBITER_RR_EN.
- Defined:
  - A last-served flag is updated at RESP.
  - When I and D requests are both pending in IDLE, the side not served last wins.
  - D write-over-read ordering is unchanged.
- Undefined: fixed D-over-I priority as above; no last-served flag.

Test Plan:
- Single I read at 0x0000_1234:
  - mem_address==0x0000_1220, mem_read held 4 beats.
  - Beats 0x11..,0x22..,0x33..,0x44.. → i_rdata={beat3,beat2,beat1,beat0}, i_resp single pulse at N+6.
- D write of line 0xDDDD...0003_..0002_..0001_..0000 at 0x8000_0040:
  - mem_write held 4 beats; mem_wdata sequence is slice0..slice3.
  - d_resp one pulse; mem_read stays 0.
- i_read and d_read raised in the same cycle:
  - D burst first, then I burst; no gap beyond RESP+IDLE.
  - With LINE_MEM_ARBITER_RR_EN and D served last, I goes first.
- Wait-state memory with mem_resp only every 3rd cycle:
  - All 4 beats captured correctly; resp at the expected cycle; outputs stable while waiting.
- rst=0 after the 2nd beat of a D read:
  - Next cycle all outputs 0 and state IDLE.
  - A fresh i_read then completes normally with the counter starting at beat 0.
- d_read and d_write both high:
  - Write burst performed; d_resp once; no read burst follows unless d_read is still high in IDLE.
